rr_mem_controller: RTL and testbench
====================================

// Module: rr_mem_controller
// PURPOSE
//  Multi-channel memory controller between NUM_CONSUMERS requesters (fetchers/LSUs) and NUM_CHANNELS
//  global-memory ports. Grants fairly via a rotating round-robin pointer and serves up to
//  NUM_CHANNELS requests concurrently. Never grants one consumer to two channels.
//  Supports read-only instances (program memory) and exposes per-channel occupancy for perf counters.
// PARAMETERS
//  ADDR_BITS      8  address width
//  DATA_BITS      16 data width
//  NUM_CONSUMERS  4  requesters, >=1
//  NUM_CHANNELS   2  concurrent memory channels, 1..NUM_CONSUMERS
//  WRITE_ENABLE   1  0: write requests never granted, all write outputs tied 0
// PORTS
//  clk                    in   1        clock
//  reset                  in   1        synchronous, active-high
//  consumer_read_valid    in   NC       per-consumer read request, held until read_ready
//  consumer_read_address  in   NC*AB    consumer j at [j*AB +: AB]
//  consumer_read_ready    out  NC       read data valid, held until consumer drops read_valid
//  consumer_read_data     out  NC*DB    consumer j at [j*DB +: DB]
//  consumer_write_valid   in   NC       per-consumer write request
//  consumer_write_address in   NC*AB
//  consumer_write_data    in   NC*DB
//  consumer_write_ready   out  NC       write done, held until consumer drops write_valid
//  mem_read_valid         out  NCH      per-channel read request
//  mem_read_address       out  NCH*AB
//  mem_read_ready         in   NCH      memory read response strobe
//  mem_read_data          in   NCH*DB
//  mem_write_valid        out  NCH
//  mem_write_address      out  NCH*AB
//  mem_write_data         out  NCH*DB
//  mem_write_ready        in   NCH
//  channel_busy           out  NCH      1 whenever channel state != IDLE
// BEHAVIOUR
//  Reset: all outputs 0; all channels IDLE; rr_ptr=0; serving mask=0. Reset mid-transaction
//   abandons it; no consumer ready is asserted afterwards for the abandoned request.
//  Per-channel FSM: IDLE -> READ_WAIT|WRITE_WAIT -> READ_RELAY|WRITE_RELAY -> IDLE.
//  IDLE: eligible = (read_valid | (write_valid & WRITE_ENABLE)) & ~serving. Scan starts at rr_ptr,
//   wrapping mod NC. In one cycle, idle channels are filled in ascending channel index, each taking
//   the next eligible consumer after the previous channel's pick. Read wins when a consumer asserts both.
//   Grant: latch consumer index, set serving bit, drive mem_*_valid/address(/data) next edge.
//  After any grant cycle, rr_ptr = (last consumer granted that cycle + 1) mod NC; unchanged otherwise.
//  READ_WAIT: on mem_read_ready -> mem_read_valid=0, consumer_read_data/ready=1 next edge, go READ_RELAY.
//  WRITE_WAIT: on mem_write_ready -> mem_write_valid=0, consumer_write_ready=1 next edge, go WRITE_RELAY.
//  RELAY: when consumer's valid is low -> ready=0, clear serving bit, go IDLE. The consumer is
//   re-grantable no earlier than the edge after IDLE is reached; no same-cycle regrant.
//  Latency: request sampled at edge t -> mem valid after t; mem ready at edge u -> consumer ready after u.
//  consumer_read_data holds the last returned value until the next read completes for that consumer.
//  Serving mask is updated with registered logic only (no blocking writes shared across channels).
//  WRITE_ENABLE=0: write_valid ignored, channels never enter WRITE states.
// TESTING
//  1 NC=4,NCH=2: consumers 0-3 read together at t0 -> ch0 gets c0, ch1 gets c1; rr_ptr=2; c2/c3 next.
//  2 c1 reads addr 0x12, memory returns 0xBEEF after 3 cycles -> consumer_read_data[1]=0xBEEF,
//    ready held until valid drops, then 0 next edge.
//  3 c2 holds read and write to 0x40 -> read served first; write granted after release.
//  4 WRITE_ENABLE=0, c0 write_valid held 20 cycles -> mem_write_valid and write_ready stay 0.
//  5 Fairness: c0 re-requests immediately, c3 waiting, NCH=1 -> c3 granted before c0's second.
//  6 Reset asserted in READ_WAIT -> all outputs 0 next edge; channel_busy=0; new request grants normally.

Source files
------------

// File: rtl/rr_mem_controller.sv
// Round-robin memory controller: NUM_CONSUMERS requesters share NUM_CHANNELS memory ports.
// Each channel runs its own grant -> wait -> relay handshake.
module rr_mem_controller #(
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 16,
  parameter int NUM_CONSUMERS = 4,
  parameter int NUM_CHANNELS  = 2,
  parameter int WRITE_ENABLE  = 1
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [NUM_CONSUMERS-1:0]            consumer_read_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0]  consumer_read_address,
  output logic [NUM_CONSUMERS-1:0]            consumer_read_ready,
  output logic [NUM_CONSUMERS*DATA_BITS-1:0]  consumer_read_data,
  input  logic [NUM_CONSUMERS-1:0]            consumer_write_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0]  consumer_write_address,
  input  logic [NUM_CONSUMERS*DATA_BITS-1:0]  consumer_write_data,
  output logic [NUM_CONSUMERS-1:0]            consumer_write_ready,
  output logic [NUM_CHANNELS-1:0]             mem_read_valid,
  output logic [NUM_CHANNELS*ADDR_BITS-1:0]   mem_read_address,
  input  logic [NUM_CHANNELS-1:0]             mem_read_ready,
  input  logic [NUM_CHANNELS*DATA_BITS-1:0]   mem_read_data,
  output logic [NUM_CHANNELS-1:0]             mem_write_valid,
  output logic [NUM_CHANNELS*ADDR_BITS-1:0]   mem_write_address,
  output logic [NUM_CHANNELS*DATA_BITS-1:0]   mem_write_data,
  input  logic [NUM_CHANNELS-1:0]             mem_write_ready,
  output logic [NUM_CHANNELS-1:0]             channel_busy
);
  localparam int CW = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;
  localparam bit WE = (WRITE_ENABLE != 0);

  typedef enum logic [2:0] {IDLE, READ_WAIT, READ_RELAY, WRITE_WAIT, WRITE_RELAY} chan_state_e;

  chan_state_e                        state_q [NUM_CHANNELS];
  chan_state_e                        state_d [NUM_CHANNELS];
  logic [CW-1:0]                      owner_q [NUM_CHANNELS];
  logic [CW-1:0]                      owner_d [NUM_CHANNELS];
  logic [ADDR_BITS-1:0]               addr_q  [NUM_CHANNELS];
  logic [ADDR_BITS-1:0]               addr_d  [NUM_CHANNELS];
  logic [DATA_BITS-1:0]               wdata_q [NUM_CHANNELS];
  logic [DATA_BITS-1:0]               wdata_d [NUM_CHANNELS];
  logic [NUM_CONSUMERS-1:0]           serving_q, serving_d;
  logic [CW-1:0]                      rr_ptr_q, rr_ptr_d;
  logic [NUM_CONSUMERS*DATA_BITS-1:0] read_data_q, read_data_d;
  logic [NUM_CONSUMERS-1:0]           eligible;

  assign eligible = (consumer_read_valid | (consumer_write_valid & {NUM_CONSUMERS{WE}})) & ~serving_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
        state_q[ch] <= IDLE;
        owner_q[ch] <= '0;
        addr_q[ch]  <= '0;
        wdata_q[ch] <= '0;
      end
      serving_q   <= '0;
      rr_ptr_q    <= '0;
      read_data_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      serving_q   <= serving_d;
      rr_ptr_q    <= rr_ptr_d;
      read_data_q <= read_data_d;
    end
  end

  // Idle channels are filled in ascending order; each scan resumes just after the previous pick.
  always_comb begin : next_state
    logic [NUM_CONSUMERS-1:0] taken;
    logic                     found;
    logic [CW-1:0]            pick;
    logic [CW-1:0]            cand;
    int                       scan;
    int                       idx;
    state_d     = state_q;
    owner_d     = owner_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    serving_d   = serving_q;
    rr_ptr_d    = rr_ptr_q;
    read_data_d = read_data_q;
    taken       = '0;
    found       = 1'b0;
    pick        = '0;
    cand        = '0;
    scan        = int'(rr_ptr_q);
    idx         = 0;
    for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
      case (state_q[ch])
        IDLE: begin
          found = 1'b0;
          pick  = '0;
          for (int k = 0; k < NUM_CONSUMERS; k++) begin
            idx = scan + k;
            if (idx >= NUM_CONSUMERS) idx = idx - NUM_CONSUMERS;
            cand = CW'(idx);
            if (!found && eligible[cand] && !taken[cand]) begin
              found = 1'b1;
              pick  = cand;
            end
          end
          if (found) begin
            taken[pick]     = 1'b1;
            serving_d[pick] = 1'b1;
            owner_d[ch]     = pick;
            if (consumer_read_valid[pick]) begin
              state_d[ch] = READ_WAIT;
              addr_d[ch]  = consumer_read_address[int'(pick)*ADDR_BITS +: ADDR_BITS];
            end else begin
              state_d[ch] = WRITE_WAIT;
              addr_d[ch]  = consumer_write_address[int'(pick)*ADDR_BITS +: ADDR_BITS];
              wdata_d[ch] = consumer_write_data[int'(pick)*DATA_BITS +: DATA_BITS];
            end
            scan     = (int'(pick) + 1 >= NUM_CONSUMERS) ? 0 : int'(pick) + 1;
            rr_ptr_d = CW'(scan);
          end
        end
        READ_WAIT: begin
          if (mem_read_ready[ch]) begin
            read_data_d[int'(owner_q[ch])*DATA_BITS +: DATA_BITS] =
              mem_read_data[ch*DATA_BITS +: DATA_BITS];
            state_d[ch] = READ_RELAY;
          end
        end
        READ_RELAY: begin
          if (!consumer_read_valid[owner_q[ch]]) begin
            state_d[ch]            = IDLE;
            serving_d[owner_q[ch]] = 1'b0;
          end
        end
        WRITE_WAIT: begin
          if (mem_write_ready[ch]) state_d[ch] = WRITE_RELAY;
        end
        WRITE_RELAY: begin
          if (!consumer_write_valid[owner_q[ch]]) begin
            state_d[ch]            = IDLE;
            serving_d[owner_q[ch]] = 1'b0;
          end
        end
        default: state_d[ch] = IDLE;
      endcase
    end
  end

  always_comb begin
    mem_read_valid       = '0;
    mem_read_address     = '0;
    mem_write_valid      = '0;
    mem_write_address    = '0;
    mem_write_data       = '0;
    channel_busy         = '0;
    consumer_read_ready  = '0;
    consumer_write_ready = '0;
    for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
      channel_busy[ch] = (state_q[ch] != IDLE);
      if (state_q[ch] == READ_WAIT) begin
        mem_read_valid[ch]                           = 1'b1;
        mem_read_address[ch*ADDR_BITS +: ADDR_BITS]  = addr_q[ch];
      end
      if (WE && state_q[ch] == WRITE_WAIT) begin
        mem_write_valid[ch]                          = 1'b1;
        mem_write_address[ch*ADDR_BITS +: ADDR_BITS] = addr_q[ch];
        mem_write_data[ch*DATA_BITS +: DATA_BITS]    = wdata_q[ch];
      end
      if (state_q[ch] == READ_RELAY) consumer_read_ready[owner_q[ch]] = 1'b1;
      if (WE && state_q[ch] == WRITE_RELAY) consumer_write_ready[owner_q[ch]] = 1'b1;
    end
  end

  assign consumer_read_data = read_data_q;

endmodule

// File: tb/tb_rr_mem_controller.sv
// Testbench for rr_mem_controller: directed vector table, hand-written corner sequences,
// and a randomized run against a queue-based arbitration model.
module tb_rr_mem_controller;
  localparam int NC  = 4;
  localparam int NCH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  rv, wv, crr, cwr;
  logic [31:0] ra, wa;
  logic [63:0] wd, crd;
  logic [1:0]  mrv, mrr, mwv, mwr, busy;
  logic [15:0] mra, mwa;
  logic [31:0] mrd, mwd;

  logic        b_rst;
  logic [3:0]  b_rv, b_wv, b_crr, b_cwr;
  logic [31:0] b_ra, b_wa;
  logic [63:0] b_wd, b_crd;
  logic [0:0]  b_mrv, b_mrr, b_mwv, b_mwr, b_busy;
  logic [7:0]  b_mra, b_mwa;
  logic [15:0] b_mrd, b_mwd;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rr_mem_controller dut (
    .clk(clk), .reset(rst),
    .consumer_read_valid(rv), .consumer_read_address(ra),
    .consumer_read_ready(crr), .consumer_read_data(crd),
    .consumer_write_valid(wv), .consumer_write_address(wa),
    .consumer_write_data(wd), .consumer_write_ready(cwr),
    .mem_read_valid(mrv), .mem_read_address(mra),
    .mem_read_ready(mrr), .mem_read_data(mrd),
    .mem_write_valid(mwv), .mem_write_address(mwa),
    .mem_write_data(mwd), .mem_write_ready(mwr),
    .channel_busy(busy)
  );

  rr_mem_controller #(.NUM_CHANNELS(1), .WRITE_ENABLE(0)) dut_ro (
    .clk(clk), .reset(b_rst),
    .consumer_read_valid(b_rv), .consumer_read_address(b_ra),
    .consumer_read_ready(b_crr), .consumer_read_data(b_crd),
    .consumer_write_valid(b_wv), .consumer_write_address(b_wa),
    .consumer_write_data(b_wd), .consumer_write_ready(b_cwr),
    .mem_read_valid(b_mrv), .mem_read_address(b_mra),
    .mem_read_ready(b_mrr), .mem_read_data(b_mrd),
    .mem_write_valid(b_mwv), .mem_write_address(b_mwa),
    .mem_write_data(b_mwd), .mem_write_ready(b_mwr),
    .channel_busy(b_busy)
  );

  typedef struct {
    logic        rst;
    logic [3:0]  rv;
    logic [1:0]  mrr;
    logic [15:0] mdata;
    logic [1:0]  e_mrv;
    logic [7:0]  e_a0;
    logic [7:0]  e_a1;
    logic [3:0]  e_crr;
    logic [1:0]  e_busy;
    logic [63:0] e_rd;
  } vec_t;

  vec_t vecs[14];

  typedef enum int {P_IDLE, P_RW, P_RR, P_WW, P_WR} ph_e;
  ph_e         m_ph[NCH];
  int          m_owner[NCH];
  logic [7:0]  m_addr[NCH];
  logic [15:0] m_wdata[NCH];
  bit          m_serving[NC];
  int          m_ptr;
  logic [15:0] m_rdata[NC];
  int          rd_cnt[NCH];
  int          wr_cnt[NCH];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    rst = v.rst;
    rv  = v.rv;
    wv  = 4'h0;
    mrr = v.mrr;
    mwr = 2'b00;
    mrd = {v.mdata, v.mdata};
  endtask

  // Reference: eligible consumers listed in rotated order from the pointer, handed out to idle channels.
  task automatic modelStep();
    int  q[$];
    int  c;
    ph_e old_ph[NCH];
    if (rst) begin
      for (int ch = 0; ch < NCH; ch++) begin
        m_ph[ch] = P_IDLE; m_owner[ch] = 0; m_addr[ch] = '0; m_wdata[ch] = '0;
      end
      for (int i = 0; i < NC; i++) begin
        m_serving[i] = 0; m_rdata[i] = '0;
      end
      m_ptr = 0;
      return;
    end
    old_ph = m_ph;
    for (int k = 0; k < NC; k++) begin
      c = (m_ptr + k) % NC;
      if ((rv[c] || wv[c]) && !m_serving[c]) q.push_back(c);
    end
    for (int ch = 0; ch < NCH; ch++) begin
      case (old_ph[ch])
        P_IDLE: if (q.size() > 0) begin
          c = q.pop_front();
          m_owner[ch] = c;
          m_serving[c] = 1;
          if (rv[c]) begin
            m_ph[ch] = P_RW; m_addr[ch] = ra[c*8 +: 8];
          end else begin
            m_ph[ch] = P_WW; m_addr[ch] = wa[c*8 +: 8]; m_wdata[ch] = wd[c*16 +: 16];
          end
          m_ptr = (c + 1) % NC;
        end
        P_RW: if (mrr[ch]) begin
          m_rdata[m_owner[ch]] = mrd[ch*16 +: 16];
          m_ph[ch] = P_RR;
        end
        P_RR: if (!rv[m_owner[ch]]) begin
          m_ph[ch] = P_IDLE; m_serving[m_owner[ch]] = 0;
        end
        P_WW: if (mwr[ch]) m_ph[ch] = P_WR;
        P_WR: if (!wv[m_owner[ch]]) begin
          m_ph[ch] = P_IDLE; m_serving[m_owner[ch]] = 0;
        end
        default: ;
      endcase
    end
  endtask

  task automatic compareModel();
    logic [1:0]  e_mrv, e_mwv, e_busy;
    logic [3:0]  e_crr, e_cwr;
    logic [63:0] e_rd;
    e_mrv = '0; e_mwv = '0; e_busy = '0; e_crr = '0; e_cwr = '0; e_rd = '0;
    for (int ch = 0; ch < NCH; ch++) begin
      e_busy[ch] = (m_ph[ch] != P_IDLE);
      e_mrv[ch]  = (m_ph[ch] == P_RW);
      e_mwv[ch]  = (m_ph[ch] == P_WW);
      if (m_ph[ch] == P_RR) e_crr[m_owner[ch]] = 1'b1;
      if (m_ph[ch] == P_WR) e_cwr[m_owner[ch]] = 1'b1;
    end
    for (int i = 0; i < NC; i++) e_rd[i*16 +: 16] = m_rdata[i];
    checkOutput("rand mem_read_valid", mrv, e_mrv);
    checkOutput("rand mem_write_valid", mwv, e_mwv);
    checkOutput("rand channel_busy", busy, e_busy);
    checkOutput("rand read_ready", crr, e_crr);
    checkOutput("rand write_ready", cwr, e_cwr);
    checkOutput("rand read_data", crd, e_rd);
    for (int ch = 0; ch < NCH; ch++) begin
      if (e_mrv[ch]) checkOutput("rand mem_read_address", mra[ch*8 +: 8], m_addr[ch]);
      if (e_mwv[ch]) begin
        checkOutput("rand mem_write_address", mwa[ch*8 +: 8], m_addr[ch]);
        checkOutput("rand mem_write_data", mwd[ch*16 +: 16], m_wdata[ch]);
      end
    end
  endtask

  task automatic driveRandom();
    rst = ($urandom_range(0, 299) == 0);
    for (int c = 0; c < NC; c++) begin
      if (rv[c] && crr[c] && $urandom_range(0, 1) == 1) rv[c] = 1'b0;
      if (wv[c] && cwr[c] && $urandom_range(0, 1) == 1) wv[c] = 1'b0;
      if (!rv[c] && !wv[c] && !crr[c] && !cwr[c] && $urandom_range(0, 3) == 0) begin
        case ($urandom_range(0, 2))
          0:       rv[c] = 1'b1;
          1:       wv[c] = 1'b1;
          default: begin rv[c] = 1'b1; wv[c] = 1'b1; end
        endcase
        ra[c*8 +: 8]  = 8'($urandom);
        wa[c*8 +: 8]  = 8'($urandom);
        wd[c*16 +: 16] = 16'($urandom);
      end
    end
    for (int ch = 0; ch < NCH; ch++) begin
      if (mrr[ch]) mrr[ch] = 1'b0;
      else if (mrv[ch]) begin
        if (rd_cnt[ch] == 0) begin
          mrr[ch] = 1'b1;
          mrd[ch*16 +: 16] = 16'($urandom);
          rd_cnt[ch] = $urandom_range(0, 3);
        end else rd_cnt[ch]--;
      end
      if (mwr[ch]) mwr[ch] = 1'b0;
      else if (mwv[ch]) begin
        if (wr_cnt[ch] == 0) begin
          mwr[ch] = 1'b1;
          wr_cnt[ch] = $urandom_range(0, 3);
        end else wr_cnt[ch]--;
      end
    end
  endtask

  initial begin
    rst = 1'b1; rv = '0; wv = '0; mrr = '0; mwr = '0; mrd = '0;
    ra = {8'h30, 8'h20, 8'h12, 8'h10}; wa = '0; wd = '0;
    b_rst = 1'b1; b_rv = '0; b_wv = '0; b_mrr = '0; b_mwr = '0; b_mrd = '0;
    b_ra = {8'h33, 8'h22, 8'h11, 8'h00}; b_wa = '0; b_wd = '0;

    vecs[0]  = '{1'b1, 4'h0, 2'b00, 16'h0000, 2'b00, 8'h00, 8'h00, 4'h0, 2'b00, 64'h0};
    vecs[1]  = '{1'b0, 4'hF, 2'b00, 16'h0000, 2'b11, 8'h10, 8'h12, 4'h0, 2'b11, 64'h0};
    vecs[2]  = '{1'b0, 4'hF, 2'b00, 16'h0000, 2'b11, 8'h10, 8'h12, 4'h0, 2'b11, 64'h0};
    vecs[3]  = '{1'b0, 4'hF, 2'b01, 16'h1234, 2'b10, 8'h00, 8'h12, 4'h1, 2'b11, 64'h0000_0000_0000_1234};
    vecs[4]  = '{1'b0, 4'hE, 2'b10, 16'hBEEF, 2'b00, 8'h00, 8'h00, 4'h2, 2'b10, 64'h0000_0000_BEEF_1234};
    vecs[5]  = '{1'b0, 4'hC, 2'b00, 16'h0000, 2'b01, 8'h20, 8'h00, 4'h0, 2'b01, 64'h0000_0000_BEEF_1234};
    vecs[6]  = '{1'b0, 4'hC, 2'b00, 16'h0000, 2'b11, 8'h20, 8'h30, 4'h0, 2'b11, 64'h0000_0000_BEEF_1234};
    vecs[7]  = '{1'b0, 4'hC, 2'b11, 16'h5555, 2'b00, 8'h00, 8'h00, 4'hC, 2'b11, 64'h5555_5555_BEEF_1234};
    vecs[8]  = '{1'b0, 4'h0, 2'b00, 16'h0000, 2'b00, 8'h00, 8'h00, 4'h0, 2'b00, 64'h5555_5555_BEEF_1234};
    vecs[9]  = '{1'b0, 4'h1, 2'b00, 16'h0000, 2'b01, 8'h10, 8'h00, 4'h0, 2'b01, 64'h5555_5555_BEEF_1234};
    vecs[10] = '{1'b1, 4'h1, 2'b00, 16'h0000, 2'b00, 8'h00, 8'h00, 4'h0, 2'b00, 64'h0};
    vecs[11] = '{1'b0, 4'h1, 2'b00, 16'h0000, 2'b01, 8'h10, 8'h00, 4'h0, 2'b01, 64'h0};
    vecs[12] = '{1'b0, 4'h1, 2'b01, 16'hCAFE, 2'b00, 8'h00, 8'h00, 4'h1, 2'b01, 64'h0000_0000_0000_CAFE};
    vecs[13] = '{1'b0, 4'h0, 2'b00, 16'h0000, 2'b00, 8'h00, 8'h00, 4'h0, 2'b00, 64'h0000_0000_0000_CAFE};

    for (int i = 0; i < 14; i++) begin
      applyStimulus(vecs[i]);
      @(negedge clk);
      checkOutput($sformatf("row%0d mem_read_valid", i), mrv, vecs[i].e_mrv);
      if (vecs[i].e_mrv[0]) checkOutput($sformatf("row%0d addr0", i), mra[7:0], vecs[i].e_a0);
      if (vecs[i].e_mrv[1]) checkOutput($sformatf("row%0d addr1", i), mra[15:8], vecs[i].e_a1);
      checkOutput($sformatf("row%0d read_ready", i), crr, vecs[i].e_crr);
      checkOutput($sformatf("row%0d channel_busy", i), busy, vecs[i].e_busy);
      checkOutput($sformatf("row%0d read_data", i), crd, vecs[i].e_rd);
      checkOutput($sformatf("row%0d mem_write_valid", i), mwv, 2'b00);
    end

    // Consumer 2 asks for read and write together: read goes first, write after release.
    rst = 1'b1; rv = '0; wv = '0; mrr = '0; mwr = '0;
    @(negedge clk);
    rst = 1'b0;
    ra[23:16] = 8'h40; wa[23:16] = 8'h40; wd[47:32] = 16'hA5A5;
    rv = 4'b0100; wv = 4'b0100;
    @(negedge clk);
    checkOutput("rw mem_read_valid", mrv, 2'b01);
    checkOutput("rw read addr", mra[7:0], 8'h40);
    checkOutput("rw no write yet", mwv, 2'b00);
    mrr = 2'b01; mrd = 32'h0000_1111;
    @(negedge clk);
    mrr = 2'b00;
    checkOutput("rw read_ready", crr, 4'b0100);
    checkOutput("rw read_data", crd[47:32], 16'h1111);
    checkOutput("rw still no write", mwv, 2'b00);
    rv = 4'b0000;
    @(negedge clk);
    checkOutput("rw ready dropped", crr, 4'b0000);
    checkOutput("rw idle gap", busy, 2'b00);
    checkOutput("rw no same-cycle regrant", mwv, 2'b00);
    @(negedge clk);
    checkOutput("rw mem_write_valid", mwv, 2'b01);
    checkOutput("rw write addr", mwa[7:0], 8'h40);
    checkOutput("rw write data", mwd[15:0], 16'hA5A5);
    mwr = 2'b01;
    @(negedge clk);
    mwr = 2'b00;
    checkOutput("rw write_ready", cwr, 4'b0100);
    checkOutput("rw write valid low", mwv, 2'b00);
    wv = 4'b0000;
    @(negedge clk);
    checkOutput("rw write_ready dropped", cwr, 4'b0000);
    checkOutput("rw final idle", busy, 2'b00);

    // Read-only instance ignores a held write request entirely.
    @(negedge clk);
    b_rst = 1'b0;
    b_wv = 4'b0001; b_wa[7:0] = 8'h55;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checkOutput($sformatf("ro cyc%0d mem_write_valid", i), b_mwv, 1'b0);
      checkOutput($sformatf("ro cyc%0d write_ready", i), b_cwr, 4'h0);
      checkOutput($sformatf("ro cyc%0d busy", i), b_busy, 1'b0);
    end
    b_wv = 4'b0000;

    // Single channel fairness: c3 waiting beats c0's immediate re-request.
    b_rst = 1'b1;
    @(negedge clk);
    b_rst = 1'b0;
    b_rv = 4'b1001;
    @(negedge clk);
    checkOutput("fair first grant addr", b_mra, 8'h00);
    checkOutput("fair first grant valid", b_mrv, 1'b1);
    b_mrr = 1'b1; b_mrd = 16'h0C0C;
    @(negedge clk);
    b_mrr = 1'b0;
    checkOutput("fair c0 ready", b_crr, 4'b0001);
    b_rv = 4'b1000;
    @(negedge clk);
    checkOutput("fair channel idle", b_busy, 1'b0);
    b_rv = 4'b1001;
    @(negedge clk);
    checkOutput("fair c3 granted valid", b_mrv, 1'b1);
    checkOutput("fair c3 granted addr", b_mra, 8'h33);
    b_mrr = 1'b1; b_mrd = 16'h3333;
    @(negedge clk);
    b_mrr = 1'b0;
    checkOutput("fair c3 ready", b_crr, 4'b1000);
    checkOutput("fair c3 data", b_crd[63:48], 16'h3333);
    b_rv = 4'b0001;
    @(negedge clk);
    @(negedge clk);
    checkOutput("fair c0 second grant addr", b_mra, 8'h00);
    checkOutput("fair c0 second grant valid", b_mrv, 1'b1);
    b_rv = 4'b0000;

    // Randomized traffic against the reference model, with occasional resets.
    rst = 1'b1; rv = '0; wv = '0; mrr = '0; mwr = '0; mrd = '0;
    for (int ch = 0; ch < NCH; ch++) begin
      rd_cnt[ch] = 0; wr_cnt[ch] = 0;
    end
    modelStep();
    @(negedge clk);
    rst = 1'b0;
    for (int it = 0; it < 3000; it++) begin
      compareModel();
      driveRandom();
      modelStep();
      @(negedge clk);
    end
    compareModel();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
